// File: rtl/pc_fetch_gen.sv
// Fetch-stage program-counter generator: valid/ready fetch handshake, trap/jump redirect, halt/resume FSM.
// Optional feature macro PC_MISALIGN_TRAP_EN turns misaligned jump targets into traps.
module pc_fetch_gen #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(32'h0000_0100),
   parameter int                    INCREMENT    = 4,
   parameter int                    COUNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   jump_enable,
   input  logic [ADDR_WIDTH-1:0]  jump_address,
   input  logic                   trap_enable,
   input  logic                   halt_req,
   input  logic                   resume_req,
   input  logic                   fetch_ready,
   output logic                   fetch_valid,
   output logic [ADDR_WIDTH-1:0]  pc_address_out,
   output logic                   misalign_trap,
   output logic [ADDR_WIDTH-1:0]  badaddr_out,
   output logic [COUNT_WIDTH-1:0] fetch_count
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [ADDR_WIDTH-1:0] INC_STEP = ADDR_WIDTH'(INCREMENT);

   state_t                 state_q, state_d;
   logic                   fetch_valid_q, fetch_valid_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   handshake;

   assign handshake = fetch_valid_q && fetch_ready;

   // State register (also holds the registered fetch_valid decode)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         fetch_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_valid_q <= fetch_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_req) state_d = HALT;
         HALT:    if (resume_req && !halt_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // fetch_valid is decoded from the next state so the output itself is a flop
   always_comb begin
      fetch_valid_d = (state_d == RUN);
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic                  misalign_q, misalign_d;
   logic [ADDR_WIDTH-1:0] badaddr_q, badaddr_d;
   logic                  jump_misaligned;

   assign jump_misaligned = jump_enable && !trap_enable && (jump_address[1:0] != 2'b00);

   always_comb begin
      misalign_d = jump_misaligned;
      badaddr_d  = jump_misaligned ? jump_address : badaddr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
         badaddr_q  <= '0;
      end else begin
         misalign_q <= misalign_d;
         badaddr_q  <= badaddr_d;
      end
   end

   assign misalign_trap = misalign_q;
   assign badaddr_out   = badaddr_q;
`else
   assign misalign_trap = 1'b0;
   assign badaddr_out   = '0;
`endif

   always_comb begin
      pc_d = pc_q;
      if (trap_enable) begin
         pc_d = TRAP_VECTOR;
      end else if (jump_enable) begin
`ifdef PC_MISALIGN_TRAP_EN
         pc_d = jump_misaligned ? TRAP_VECTOR : jump_address;
`else
         pc_d = jump_address & ~ADDR_WIDTH'(3);
`endif
      end else if (state_q != RUN || stall) begin
         pc_d = pc_q;
      end else if (handshake) begin
         pc_d = pc_q + INC_STEP;
      end
   end

   // Accepted fetches are counted even when a redirect or stall wins the PC
   always_comb begin
      count_d = handshake ? count_q + COUNT_WIDTH'(1) : count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   assign fetch_valid    = fetch_valid_q;
   assign pc_address_out = pc_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed self-checking bench for pc_fetch_gen: a 32-bit instance for the main flow
// and an 8-bit / 4-bit-count instance for wrap-around. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_fetch_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst, stall, jump_enable, trap_enable, halt_req, resume_req, fetch_ready;
   logic [31:0] jump_address;
   logic        fetch_valid, misalign_trap;
   logic [31:0] pc_address_out, badaddr_out, fetch_count;

   logic        w_rst;
   logic        w_valid, w_mis;
   logic [7:0]  w_pc, w_bad;
   logic [3:0]  w_count;

   pc_fetch_gen #(
      .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
      .INCREMENT(4), .COUNT_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .jump_enable(jump_enable),
      .jump_address(jump_address), .trap_enable(trap_enable), .halt_req(halt_req),
      .resume_req(resume_req), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
      .pc_address_out(pc_address_out), .misalign_trap(misalign_trap),
      .badaddr_out(badaddr_out), .fetch_count(fetch_count)
   );

   pc_fetch_gen #(
      .ADDR_WIDTH(8), .RESET_VECTOR(8'hF0), .TRAP_VECTOR(8'h80),
      .INCREMENT(4), .COUNT_WIDTH(4)
   ) dut_w (
      .clk(clk), .rst(w_rst), .stall(1'b0), .jump_enable(1'b0),
      .jump_address(8'h00), .trap_enable(1'b0), .halt_req(1'b0),
      .resume_req(1'b0), .fetch_ready(1'b1), .fetch_valid(w_valid),
      .pc_address_out(w_pc), .misalign_trap(w_mis),
      .badaddr_out(w_bad), .fetch_count(w_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [31:0] pc, input logic fv, input logic [31:0] cnt);
      chk({tag, ".pc"}, 64'(pc_address_out), 64'(pc));
      chk({tag, ".valid"}, 64'(fetch_valid), 64'(fv));
      chk({tag, ".count"}, 64'(fetch_count), 64'(cnt));
      $display("step %-12s pc=%08h valid=%0d count=%0d mis=%0d bad=%08h",
               tag, pc_address_out, fetch_valid, fetch_count, misalign_trap, badaddr_out);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; jump_enable = 1'b0; trap_enable = 1'b0;
      halt_req = 1'b0; resume_req = 1'b0; fetch_ready = 1'b1; jump_address = 32'h0;
      w_rst = 1'b1;

      // Reset and boot
      step(); step();
      chk_main("reset", 32'h0, 1'b0, 32'd0);
      chk("reset.mis", 64'(misalign_trap), 64'd0);
      chk("reset.bad", 64'(badaddr_out), 64'd0);
      rst = 1'b0;
      step(); chk_main("boot", 32'h0, 1'b1, 32'd0);
      step(); chk_main("seq1", 32'h4, 1'b1, 32'd1);
      step(); chk_main("seq2", 32'h8, 1'b1, 32'd2);

      // Back-pressure then stall
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_main("bp", 32'h8, 1'b1, 32'd2);
      end
      fetch_ready = 1'b1; stall = 1'b1;
      step(); chk_main("stall1", 32'h8, 1'b1, 32'd3);
      step(); chk_main("stall2", 32'h8, 1'b1, 32'd4);
      stall = 1'b0;
      step(); chk_main("unstall", 32'hC, 1'b1, 32'd5);

      // Trap beats jump; plain jump
      trap_enable = 1'b1; jump_enable = 1'b1; jump_address = 32'h40;
      step(); chk_main("trap_prio", 32'h100, 1'b1, 32'd6);
      trap_enable = 1'b0;
      step(); chk_main("jump40", 32'h40, 1'b1, 32'd7);
      jump_address = 32'h20;
      step(); chk_main("jump20", 32'h20, 1'b1, 32'd8);
      jump_enable = 1'b0;

      // Halt / resume
      halt_req = 1'b1; fetch_ready = 1'b0;
      step(); chk_main("halt", 32'h20, 1'b0, 32'd8);
      fetch_ready = 1'b1; resume_req = 1'b1;
      step(); chk_main("halt_both", 32'h20, 1'b0, 32'd8);
      halt_req = 1'b0;
      step(); chk_main("resume", 32'h20, 1'b1, 32'd8);
      resume_req = 1'b0;
      step(); chk_main("run24", 32'h24, 1'b1, 32'd9);

      // Jump while halted
      halt_req = 1'b1; fetch_ready = 1'b0;
      step(); chk_main("halt2", 32'h24, 1'b0, 32'd9);
      halt_req = 1'b0; jump_enable = 1'b1; jump_address = 32'h40; fetch_ready = 1'b1;
      step(); chk_main("halt_jump", 32'h40, 1'b0, 32'd9);
      jump_enable = 1'b0; resume_req = 1'b1;
      step(); chk_main("resume2", 32'h40, 1'b1, 32'd9);
      resume_req = 1'b0;

      // Misaligned jump
      jump_enable = 1'b1; jump_address = 32'h42;
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk_main("mis_jump", 32'h100, 1'b1, 32'd10);
      chk("mis_jump.mis", 64'(misalign_trap), 64'd1);
      chk("mis_jump.bad", 64'(badaddr_out), 64'h42);
`else
      chk_main("mis_jump", 32'h40, 1'b1, 32'd10);
      chk("mis_jump.mis", 64'(misalign_trap), 64'd0);
      chk("mis_jump.bad", 64'(badaddr_out), 64'd0);
`endif
      jump_enable = 1'b0;
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk_main("mis_after", 32'h104, 1'b1, 32'd11);
      chk("mis_after.mis", 64'(misalign_trap), 64'd0);
      chk("mis_after.bad", 64'(badaddr_out), 64'h42);
`else
      chk_main("mis_after", 32'h44, 1'b1, 32'd11);
      chk("mis_after.mis", 64'(misalign_trap), 64'd0);
`endif
      trap_enable = 1'b1; jump_enable = 1'b1; jump_address = 32'h43;
      step();
      chk_main("mis_trap", 32'h100, 1'b1, 32'd12);
      chk("mis_trap.mis", 64'(misalign_trap), 64'd0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_trap.bad", 64'(badaddr_out), 64'h42);
`endif
      trap_enable = 1'b0; jump_enable = 1'b0;

      // Reset during a live handshake is not counted
      rst = 1'b1;
      step(); chk_main("mid_reset", 32'h0, 1'b0, 32'd0);

      // Narrow instance: PC and counter wrap
      w_rst = 1'b0;
      step();
      chk("w_boot.pc", 64'(w_pc), 64'hF0);
      chk("w_boot.valid", 64'(w_valid), 64'd1);
      step(); step(); step();
      chk("w_fc.pc", 64'(w_pc), 64'hFC);
      step();
      chk("w_wrap.pc", 64'(w_pc), 64'h00);
      chk("w_wrap.count", 64'(w_count), 64'd4);
      $display("step %-12s pc=%02h count=%0d", "w_wrap", w_pc, w_count);
      for (int i = 0; i < 11; i++) step();
      chk("w_c15.count", 64'(w_count), 64'd15);
      step();
      chk("w_c16.count", 64'(w_count), 64'd0);
      chk("w_c16.pc", 64'(w_pc), 64'h30);
      chk("w_c16.mis", 64'(w_mis), 64'd0);
      $display("step %-12s pc=%02h count=%0d bad=%02h", "w_cwrap", w_pc, w_count, w_bad);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
